// File: rtl/cpu_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the 8-bit lab CPU datapath.
// Optional run watchdog: define SEQ_WATCHDOG_EN to bound retirements per run to RUN_LIMIT.
module cpu_step_sequencer #(
    parameter int OP_W      = 3,
    parameter int CNT_W     = 8,
    parameter int RUN_LIMIT = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_pulse,
    input  logic             run_pulse,
    input  logic             man_pulse,
    input  logic             stop_pulse,
    input  logic             clr_pulse,
    input  logic [OP_W-1:0]  opcode,
    input  logic             equals,
    output logic             ir_load,
    output logic             ir_sel,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             dm_we,
    output logic             rf_we,
    output logic             alu_en,
    output logic             mem_clr,
    output logic             busy,
    output logic             halted,
    output logic             wdog_trip,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_STORE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MOVE  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ALU   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_HALT  = {OP_W{1'b1}};

    state_t           state_r, state_nx_s;
    logic             run_mode_r, run_mode_nx_s;
    logic             stop_r, stop_nx_s;
    logic             ir_sel_nx_s;
    logic [CNT_W-1:0] count_nx_s;
    logic             trip_nx_s;
    logic             run_start_s, run_retire_s, wd_hit_s;
    logic             exec_op_s, taken_s;
    logic             ir_load_nx_s, pc_inc_nx_s, pc_load_nx_s;
    logic             dm_we_nx_s, rf_we_nx_s, alu_en_nx_s;
    logic             busy_nx_s, halted_nx_s;

    assign exec_op_s = (opcode == OP_STORE) || (opcode == OP_MOVE) ||
                       (opcode == OP_ALU)   || (opcode == OP_BEQ);
    assign taken_s   = (opcode == OP_BEQ) && equals;

    // Next state, run/stop latches and retirement bookkeeping; clear overrides everything
    always_comb begin
        state_nx_s    = state_r;
        run_mode_nx_s = run_mode_r;
        stop_nx_s     = stop_r;
        ir_sel_nx_s   = ir_sel;
        count_nx_s    = instr_count;
        trip_nx_s     = wdog_trip;
        run_start_s   = 1'b0;
        run_retire_s  = 1'b0;
        if (clr_pulse) begin
            state_nx_s    = S_IDLE;
            run_mode_nx_s = 1'b0;
            stop_nx_s     = 1'b0;
            count_nx_s    = {CNT_W{1'b0}};
            trip_nx_s     = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (man_pulse) begin
                        ir_sel_nx_s = 1'b1;
                        state_nx_s  = S_FETCH;
                    end else if (step_pulse) begin
                        ir_sel_nx_s = 1'b0;
                        state_nx_s  = S_FETCH;
                    end else if (run_pulse) begin
                        ir_sel_nx_s   = 1'b0;
                        run_mode_nx_s = 1'b1;
                        run_start_s   = 1'b1;
                        state_nx_s    = S_FETCH;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_FETCH: begin
                    stop_nx_s  = stop_r | stop_pulse;
                    state_nx_s = S_DECODE;
                end
                S_DECODE: begin
                    stop_nx_s = stop_r | stop_pulse;
                    if (opcode == OP_HALT) begin
                        state_nx_s    = S_HALT;
                        run_mode_nx_s = 1'b0;
                        stop_nx_s     = 1'b0;
                    end else if (exec_op_s) begin
                        state_nx_s = S_EXEC;
                    end else begin
                        state_nx_s = S_WB;
                    end
                end
                S_EXEC: begin
                    stop_nx_s  = stop_r | stop_pulse;
                    state_nx_s = S_WB;
                end
                S_WB: begin
                    count_nx_s   = (instr_count == {CNT_W{1'b1}}) ? instr_count
                                                                  : instr_count + CNT_W'(1);
                    run_retire_s = run_mode_r;
                    stop_nx_s    = 1'b0;
                    if (wd_hit_s) begin
                        state_nx_s    = S_HALT;
                        run_mode_nx_s = 1'b0;
                        trip_nx_s     = 1'b1;
                    end else if (run_mode_r && !(stop_r || stop_pulse)) begin
                        state_nx_s = S_FETCH;
                    end else begin
                        state_nx_s    = S_IDLE;
                        run_mode_nx_s = 1'b0;
                    end
                end
                S_HALT: begin
                    state_nx_s    = S_HALT;
                    run_mode_nx_s = 1'b0;
                end
                default: begin
                    state_nx_s    = S_IDLE;
                    run_mode_nx_s = 1'b0;
                    stop_nx_s     = 1'b0;
                end
            endcase
        end
    end

    // Strobes are decoded from the state being entered so they appear in that state's cycle
    always_comb begin
        ir_load_nx_s = (state_nx_s == S_FETCH);
        dm_we_nx_s   = 1'b0;
        alu_en_nx_s  = 1'b0;
        rf_we_nx_s   = 1'b0;
        pc_inc_nx_s  = 1'b0;
        pc_load_nx_s = 1'b0;
        if (state_nx_s == S_EXEC) begin
            dm_we_nx_s  = (opcode == OP_STORE);
            alu_en_nx_s = (opcode == OP_ALU) || (opcode == OP_BEQ);
        end else if (state_nx_s == S_WB) begin
            rf_we_nx_s   = (opcode == OP_MOVE) || (opcode == OP_ALU);
            pc_load_nx_s = !ir_sel && taken_s;
            pc_inc_nx_s  = !ir_sel && !taken_s;
        end else begin
            dm_we_nx_s = 1'b0;
        end
        busy_nx_s   = state_nx_s inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
        halted_nx_s = (state_nx_s == S_HALT);
    end

    // State, latches and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            run_mode_r  <= 1'b0;
            stop_r      <= 1'b0;
            ir_sel      <= 1'b0;
            ir_load     <= 1'b0;
            pc_inc      <= 1'b0;
            pc_load     <= 1'b0;
            dm_we       <= 1'b0;
            rf_we       <= 1'b0;
            alu_en      <= 1'b0;
            mem_clr     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            wdog_trip   <= 1'b0;
            instr_count <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            run_mode_r  <= run_mode_nx_s;
            stop_r      <= stop_nx_s;
            ir_sel      <= ir_sel_nx_s;
            ir_load     <= ir_load_nx_s;
            pc_inc      <= pc_inc_nx_s;
            pc_load     <= pc_load_nx_s;
            dm_we       <= dm_we_nx_s;
            rf_we       <= rf_we_nx_s;
            alu_en      <= alu_en_nx_s;
            mem_clr     <= clr_pulse;
            busy        <= busy_nx_s;
            halted      <= halted_nx_s;
            wdog_trip   <= trip_nx_s;
            instr_count <= count_nx_s;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(RUN_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Retirements within the current run; restarted by every run start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (run_start_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (run_retire_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign wd_hit_s = run_mode_r && ((wd_cnt_r + WD_W'(1)) == WD_W'(RUN_LIMIT));
`else
    // Watchdog absent: never trips, runs are unbounded
    assign wd_hit_s = 1'b0 & run_start_s & run_retire_s & (RUN_LIMIT > 0);
`endif

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Self-checking bench for cpu_step_sequencer: instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized button traffic.
module tb_cpu_step_sequencer;
    localparam int RUN_LIMIT = 32;

    logic       clk = 1'b0;
    logic       reset_n, step_pulse, run_pulse, man_pulse, stop_pulse, clr_pulse;
    logic [2:0] opcode;
    logic       equals;
    logic       ir_load, ir_sel, pc_inc, pc_load, dm_we, rf_we, alu_en, mem_clr;
    logic       busy, halted, wdog_trip;
    logic [7:0] instr_count;

    always #5 clk = ~clk;

    cpu_step_sequencer #(.OP_W(3), .CNT_W(8), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .step_pulse(step_pulse), .run_pulse(run_pulse),
        .man_pulse(man_pulse), .stop_pulse(stop_pulse), .clr_pulse(clr_pulse),
        .opcode(opcode), .equals(equals), .ir_load(ir_load), .ir_sel(ir_sel),
        .pc_inc(pc_inc), .pc_load(pc_load), .dm_we(dm_we), .rf_we(rf_we), .alu_en(alu_en),
        .mem_clr(mem_clr), .busy(busy), .halted(halted), .wdog_trip(wdog_trip),
        .instr_count(instr_count)
    );

    int checks = 0;
    int passed = 0;

    // Program the bench plays back as instruction memory, plus the switch bus
    logic [2:0] imem [16];
    logic       eqm  [16];
    logic [3:0] tgt  [16];
    logic [2:0] sw_op;
    logic       sw_eq;

    // Reference model: one in-flight instruction described by its position in its own timeline
    int         m_cur, m_len, m_cnt, m_wcnt;
    logic [2:0] m_op;
    logic       m_eq, m_sel, m_run, m_stop, m_halt, m_trip, m_clr;
    logic [3:0] m_pc, m_ipc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic int len_of(input logic [2:0] op);
        if (op == 3'd7) return 2;
        if (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd5) return 4;
        return 3;
    endfunction

    task automatic start_instr(input logic sel);
        m_sel = sel;
        m_ipc = m_pc;
        m_op  = sel ? sw_op : imem[m_pc];
        m_eq  = sel ? sw_eq : eqm[m_pc];
        m_len = len_of(m_op);
        m_cur = 1;
    endtask

    task automatic model_step();
        logic hit;
        m_clr = 1'b0;
        if (clr_pulse) begin
            m_cur = 0; m_halt = 1'b0; m_run = 1'b0; m_stop = 1'b0;
            m_cnt = 0; m_trip = 1'b0; m_pc = 4'd0; m_clr = 1'b1;
        end else if (m_halt) begin
            m_run = 1'b0;
        end else if (m_cur == 0) begin
            if (man_pulse) start_instr(1'b1);
            else if (step_pulse) start_instr(1'b0);
            else if (run_pulse) begin m_run = 1'b1; m_wcnt = 0; start_instr(1'b0); end
        end else begin
            m_stop = m_stop | stop_pulse;
            if (m_cur < m_len) begin
                m_cur++;
            end else if (m_op == 3'd7) begin
                m_halt = 1'b1; m_run = 1'b0; m_stop = 1'b0; m_cur = 0;
            end else begin
                if (m_cnt < 255) m_cnt++;
                if (!m_sel) m_pc = (m_op == 3'd5 && m_eq) ? tgt[m_ipc] : m_pc + 4'd1;
                hit = 1'b0;
`ifdef SEQ_WATCHDOG_EN
                if (m_run) begin m_wcnt++; hit = (m_wcnt >= RUN_LIMIT); end
`endif
                if (hit) begin
                    m_halt = 1'b1; m_trip = 1'b1; m_run = 1'b0; m_stop = 1'b0; m_cur = 0;
                end else if (m_run && !m_stop) begin
                    start_instr(1'b0);
                end else begin
                    m_cur = 0; m_run = 1'b0; m_stop = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [18:0] model_outputs();
        logic ex, wb, tk;
        ex = (m_len == 4) && (m_cur == 3);
        wb = (m_cur != 0) && (m_cur == m_len) && (m_op != 3'd7);
        tk = (m_op == 3'd5) && m_eq;
        return {m_cur == 1, m_sel, wb && !m_sel && !tk, wb && !m_sel && tk, ex && (m_op == 3'd0),
                wb && (m_op == 3'd1 || m_op == 3'd2), ex && (m_op == 3'd2 || m_op == 3'd5),
                m_clr, m_cur != 0, m_halt, m_trip, 8'(m_cnt)};
    endfunction

    // Model advances on each active edge; DUT compared mid-cycle, then the IR opcode is presented
    initial begin
        m_cur = 0; m_len = 0; m_cnt = 0; m_wcnt = 0; m_op = 3'd0; m_eq = 1'b0; m_sel = 1'b0;
        m_run = 1'b0; m_stop = 1'b0; m_halt = 1'b0; m_trip = 1'b0; m_clr = 1'b0;
        m_pc = 4'd0; m_ipc = 4'd0; opcode = 3'd0; equals = 1'b0;
        forever begin
            @(posedge clk);
            if (reset_n) model_step();
            @(negedge clk);
            chk("outputs", {13'd0, ir_load, ir_sel, pc_inc, pc_load, dm_we, rf_we, alu_en,
                            mem_clr, busy, halted, wdog_trip, instr_count},
                {13'd0, model_outputs()});
            opcode = m_op;
            equals = m_eq;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise one button for one cycle; returns at the middle of the following cycle
    task automatic press(input int which);
        @(negedge clk);
        step_pulse = (which == 0); run_pulse = (which == 1); man_pulse = (which == 2);
        stop_pulse = (which == 3); clr_pulse = (which == 4);
        @(negedge clk);
        step_pulse = 1'b0; run_pulse = 1'b0; man_pulse = 1'b0; stop_pulse = 1'b0; clr_pulse = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic fill_imem(input logic [2:0] op);
        for (int i = 0; i < 16; i++) begin imem[i] = op; eqm[i] = 1'b0; tgt[i] = 4'd0; end
    endtask

    initial begin
        reset_n = 1'b0; step_pulse = 1'b0; run_pulse = 1'b0; man_pulse = 1'b0;
        stop_pulse = 1'b0; clr_pulse = 1'b0; sw_op = 3'd0; sw_eq = 1'b0;
        fill_imem(3'd1);
        imem[0] = 3'd0;
        imem[1] = 3'd5; eqm[1] = 1'b1; tgt[1] = 4'd4;
        imem[4] = 3'd5; eqm[4] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_outputs", {13'd0, ir_load, ir_sel, pc_inc, pc_load, dm_we, rf_we, alu_en,
                              mem_clr, busy, halted, wdog_trip, instr_count}, 32'd0);

        // Step a store: ir_load T+1, dm_we T+3, pc_inc T+4, idle with count 1 at T+5
        press(0);
        chk("store_ir_load", {31'd0, ir_load}, 32'd1);
        tick(); tick();
        chk("store_dm_we", {31'd0, dm_we}, 32'd1);
        tick();
        chk("store_pc_inc", {31'd0, pc_inc}, 32'd1);
        tick();
        chk("store_busy_done", {31'd0, busy}, 32'd0);
        chk("store_count", {24'd0, instr_count}, 32'd1);

        // Branch taken, then branch not taken
        press(0);
        tick(); tick(); tick();
        chk("beq_taken_pc_load", {30'd0, pc_load, pc_inc}, 32'd2);
        tick();
        press(0);
        tick(); tick(); tick();
        chk("beq_not_taken_pc_inc", {30'd0, pc_load, pc_inc}, 32'd1);
        tick();

        // Manual ALU op from the switches
        sw_op = 3'd2; sw_eq = 1'b1;
        press(2);
        chk("man_ir_sel", {31'd0, ir_sel}, 32'd1);
        tick(); tick();
        chk("man_alu_en", {31'd0, alu_en}, 32'd1);
        tick();
        chk("man_rf_we_no_pc", {29'd0, rf_we, pc_load, pc_inc}, 32'd4);
        tick();

        // Clear, then run 001, 010, 111 to HALT; a step in HALT changes nothing
        press(4);
        chk("clr_mem_clr", {31'd0, mem_clr}, 32'd1);
        chk("clr_count", {24'd0, instr_count}, 32'd0);
        imem[0] = 3'd1; imem[1] = 3'd2; imem[2] = 3'd7;
        press(1);
        wait_halted("run_to_halt", 20);
        chk("halt_count", {24'd0, instr_count}, 32'd2);
        press(0);
        repeat (4) tick();
        chk("halt_ignores_step", {29'd0, halted, busy, ir_load}, 32'd4);
        chk("halt_count_kept", {24'd0, instr_count}, 32'd2);

        // Stop during EXEC of the third instruction of a run
        press(4);
        fill_imem(3'd1);
        imem[2] = 3'd0;
        press(1);
        repeat (10) tick();
        stop_pulse = 1'b1;
        chk("run_third_exec_dm_we", {31'd0, dm_we}, 32'd1);
        tick();
        stop_pulse = 1'b0;
        tick();
        chk("stop_idle", {31'd0, busy}, 32'd0);
        chk("stop_count", {24'd0, instr_count}, 32'd3);
        repeat (4) tick();
        chk("stop_stays_idle", {31'd0, busy}, 32'd0);

        // Clear landing in the EXEC slot of a store suppresses its dm_we
        press(4);
        imem[0] = 3'd0;
        press(0);
        tick();
        clr_pulse = 1'b1;
        tick();
        clr_pulse = 1'b0;
        chk("clr_exec_no_dm_we", {30'd0, dm_we, mem_clr}, 32'd1);
        tick();
        chk("clr_exec_idle", {31'd0, busy}, 32'd0);
        chk("clr_exec_count", {24'd0, instr_count}, 32'd0);

        // Retired-instruction counter saturates
        fill_imem(3'd1);
        for (int i = 0; i < 260; i++) begin press(0); repeat (4) tick(); end
        chk("count_saturates", {24'd0, instr_count}, 32'd255);

        press(4);
`ifdef SEQ_WATCHDOG_EN
        press(1);
        wait_halted("wdog_halt", RUN_LIMIT * 4 + 20);
        chk("wdog_trip_set", {31'd0, wdog_trip}, 32'd1);
        chk("wdog_count", {24'd0, instr_count}, 32'd32);
        press(4);
        chk("wdog_trip_cleared", {31'd0, wdog_trip}, 32'd0);
`else
        press(1);
        repeat (170) tick();
        chk("run_unbounded", {30'd0, halted, busy}, 32'd1);
        chk("no_wdog_trip", {31'd0, wdog_trip}, 32'd0);
        press(3);
        repeat (6) tick();
        chk("run_stopped", {31'd0, busy}, 32'd0);
`endif

        // Randomized program and button traffic
        press(4);
        for (int i = 0; i < 16; i++) begin
            imem[i] = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            eqm[i]  = 1'($urandom_range(0, 1));
            tgt[i]  = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            step_pulse = ($urandom_range(0, 9) == 0);
            run_pulse  = ($urandom_range(0, 19) == 0);
            man_pulse  = ($urandom_range(0, 19) == 0);
            stop_pulse = ($urandom_range(0, 29) == 0);
            clr_pulse  = ($urandom_range(0, 59) == 0);
            sw_op      = 3'($urandom_range(0, 7));
            sw_eq      = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        step_pulse = 1'b0; run_pulse = 1'b0; man_pulse = 1'b0; stop_pulse = 1'b0; clr_pulse = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
